// File: rtl/sm_mcu_sysid_pkg.sv
// Shared types and constants for the sysid two-master read arbiter.
package sm_mcu_sysid_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

endpackage

// File: rtl/sm_mcu_rr_arb2.sv
// Two-requester grant selection: round-robin on ties, or master 0 wins ties when fixed_priority is set.
module sm_mcu_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       fixed_priority,
  output logic       grant
);

  always_comb begin
    grant = 1'b0;
    if (req == 2'b11) begin
      grant = fixed_priority ? 1'b0 : ~last_grant;
    end else if (req[1]) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/sm_mcu_sysid_arbiter.sv
// Arbitrates two read-only masters onto a single combinational sysid slave, one read per 3 cycles.
module sm_mcu_sysid_arbiter
  import sm_mcu_sysid_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_read,
  input  logic              m0_address,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic              m1_read,
  input  logic              m1_address,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic              s_address,
  input  logic [DATA_W-1:0] s_readdata
);

  state_t            state;
  state_t            state_nxt;
  logic              grant;
  logic              grant_nxt;
  logic              last_grant;
  logic              last_grant_nxt;
  logic              arb_grant;
  logic              capture;
  logic              gnt_read;
  logic              gnt_addr;
  logic [DATA_W-1:0] m0_data;
  logic [DATA_W-1:0] m1_data;

  sm_mcu_rr_arb2 u_arb (
    .req            ({m1_read, m0_read}),
    .last_grant     (last_grant),
    .fixed_priority (FIXED_PRIORITY),
    .grant          (arb_grant)
  );

  assign gnt_read = grant ? m1_read    : m0_read;
  assign gnt_addr = grant ? m1_address : m0_address;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // A grant whose request vanished before the ISSUE cycle is dropped silently,
  // leaving the fairness history untouched.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    capture        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (m0_read || m1_read) begin
          grant_nxt = arb_grant;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (gnt_read) begin
          capture        = 1'b1;
          last_grant_nxt = grant;
          state_nxt      = ST_RESP;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m0_data <= '0;
      m1_data <= '0;
    end else if (capture) begin
      if (grant) begin
        m1_data <= s_readdata;
      end else begin
        m0_data <= s_readdata;
      end
    end
  end

  assign s_address        = (state == ST_ISSUE) ? gnt_addr : SYSID_ADDR_ID;
  assign m0_waitrequest   = m0_read && !((state == ST_ISSUE) && (grant == 1'b0));
  assign m1_waitrequest   = m1_read && !((state == ST_ISSUE) && (grant == 1'b1));
  assign m0_readdatavalid = (state == ST_RESP) && (grant == 1'b0);
  assign m1_readdatavalid = (state == ST_RESP) && (grant == 1'b1);
  assign m0_readdata      = m0_data;
  assign m1_readdata      = m1_data;

endmodule

// File: tb/tb_sm_mcu_sysid_arbiter.sv
// Scoreboard bench for sm_mcu_sysid_arbiter: directed scenarios plus randomized traffic against a cycle-slot model.
module tb_sm_mcu_sysid_arbiter;
  import sm_mcu_sysid_pkg::*;

  localparam logic [31:0] TS_WORD = 32'h5409_7537;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        m0_read = 1'b0, m0_address = 1'b0;
  logic        m1_read = 1'b0, m1_address = 1'b0;
  logic        m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata, s_readdata;
  logic        s_address;
  logic        f0_waitrequest, f0_readdatavalid, f1_waitrequest, f1_readdatavalid;
  logic [31:0] f0_readdata, f1_readdata, fs_readdata;
  logic        fs_address;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] slave_word(input logic a);
    return (a == SYSID_ADDR_TS) ? TS_WORD : 32'h0;
  endfunction

  assign s_readdata  = slave_word(s_address);
  assign fs_readdata = slave_word(fs_address);

  sm_mcu_sysid_arbiter #(.DATA_W(32), .FIXED_PRIORITY(1'b0)) dut (
    .clock(clock), .reset(reset),
    .m0_read(m0_read), .m0_address(m0_address), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_read(m1_read), .m1_address(m1_address), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_readdata(s_readdata)
  );

  sm_mcu_sysid_arbiter #(.DATA_W(32), .FIXED_PRIORITY(1'b1)) dut_fp (
    .clock(clock), .reset(reset),
    .m0_read(m0_read), .m0_address(m0_address), .m0_waitrequest(f0_waitrequest),
    .m0_readdata(f0_readdata), .m0_readdatavalid(f0_readdatavalid),
    .m1_read(m1_read), .m1_address(m1_address), .m1_waitrequest(f1_waitrequest),
    .m1_readdata(f1_readdata), .m1_readdatavalid(f1_readdatavalid),
    .s_address(fs_address), .s_readdata(fs_readdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the arbiter is "free" from cycle next_free on; a request seen
  // in a free cycle wins a slot whose issue cycle is the following one.
  typedef struct { int m; logic [31:0] d; int due; } rsp_t;
  rsp_t        exp_q[$];
  int          next_free = 0;
  int          gr_cyc    = -1;
  int          gr_m      = 0;
  int          last_m    = 1;
  logic [31:0] held [2]  = '{32'h0, 32'h0};

  always @(negedge clock) begin
    logic [1:0] rd, ad, ew;
    logic       esa;
    int         upd_m;
    rd = {m1_read, m0_read};
    ad = {m1_address, m0_address};
    ew = rd;
    esa = 1'b0;
    upd_m = -1;
    if (reset) begin
      exp_q.delete();
      gr_cyc = -1;
      last_m = 1;
      next_free = cyc + 1;
      held[0] = '0;
      held[1] = '0;
    end else if (gr_cyc == cyc) begin
      ew[gr_m] = 1'b0;
      esa = ad[gr_m];
      if (rd[gr_m]) begin
        exp_q.push_back('{gr_m, slave_word(ad[gr_m]), cyc + 1});
        last_m = gr_m;
        upd_m = gr_m;
        next_free = cyc + 2;
      end else begin
        next_free = cyc + 1;
      end
      gr_cyc = -1;
    end else if (cyc >= next_free && rd != 2'b00) begin
      if (rd == 2'b11) gr_m = 1 - last_m;
      else             gr_m = rd[1] ? 1 : 0;
      gr_cyc = cyc + 1;
      next_free = cyc + 1000000;
    end
    chk("m0_waitrequest", {31'b0, m0_waitrequest}, {31'b0, ew[0]});
    chk("m1_waitrequest", {31'b0, m1_waitrequest}, {31'b0, ew[1]});
    chk("s_address", {31'b0, s_address}, {31'b0, esa});
    chk("m0_readdata_hold", m0_readdata, held[0]);
    chk("m1_readdata_hold", m1_readdata, held[1]);
    if (upd_m >= 0) held[upd_m] = slave_word(ad[upd_m]);
  end

  // Monitor: pops the scoreboard whenever a response is presented.
  always @(negedge clock) begin
    logic [1:0] vld;
    logic [31:0] dat [2];
    rsp_t e;
    vld = {m1_readdatavalid, m0_readdatavalid};
    dat[0] = m0_readdata;
    dat[1] = m1_readdata;
    for (int m = 0; m < 2; m++) begin
      if (vld[m]) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_valid: m%0d readdatavalid=1 with nothing expected (cycle %0d)", m, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_master", m, e.m);
          chk("rsp_data", dat[m], e.d);
          chk("rsp_cycle", cyc, e.due);
        end
      end
    end
    if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
      e = exp_q.pop_front();
      tests++; fails++;
      $display("FAIL missing_valid: m%0d no response, required at cycle %0d (now %0d)", e.m, e.due, cyc);
    end
  end

  int cnt_en = 0;
  int c0 = 0, c1 = 0, f0 = 0, f1 = 0;
  always @(negedge clock) begin
    if (cnt_en != 0) begin
      c0 += int'(m0_readdatavalid);
      c1 += int'(m1_readdatavalid);
      f0 += int'(f0_readdatavalid);
      f1 += int'(f1_readdatavalid);
    end
  end

  task automatic set_req(input int m, input logic r, input logic a);
    if (m == 0) begin m0_read = r; m0_address = a; end
    else        begin m1_read = r; m1_address = a; end
  endtask

  task automatic master_req(input int m, input logic a);
    int  n;
    logic w;
    @(posedge clock); #1;
    set_req(m, 1'b1, a);
    n = 0;
    do begin
      @(negedge clock);
      n++;
      w = (m == 0) ? m0_waitrequest : m1_waitrequest;
    end while (w && n < 40);
    if (w) begin
      tests++; fails++;
      $display("FAIL accept_timeout: m%0d waitrequest still 1 after %0d cycles, required 0", m, n);
    end
    @(posedge clock); #1;
    set_req(m, 1'b0, a);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clock); #1 reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic clr_cnt();
    c0 = 0; c1 = 0; f0 = 0; f1 = 0;
  endtask

  task automatic rand_master(input int m, input int iters);
    repeat (iters) begin
      repeat ($urandom_range(0, 4)) @(posedge clock);
      if ($urandom_range(0, 5) == 0) begin
        @(posedge clock); #1;
        set_req(m, 1'b1, 1'($urandom_range(0, 1)));
        repeat ($urandom_range(1, 3)) @(posedge clock);
        #1 set_req(m, 1'b0, 1'b0);
      end else begin
        master_req(m, 1'($urandom_range(0, 1)));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    reset = 1'b0;

    // single read of the timestamp word
    master_req(0, SYSID_ADDR_TS);
    idle(3);

    // simultaneous requests after reset: master 0 first
    do_reset();
    fork
      master_req(0, SYSID_ADDR_ID);
      master_req(1, SYSID_ADDR_TS);
    join
    idle(3);

    // continuous requests from both masters for 12 cycles
    do_reset();
    clr_cnt();
    cnt_en = 1;
    m0_read = 1'b1; m0_address = 1'b1;
    m1_read = 1'b1; m1_address = 1'b0;
    idle(12);
    m0_read = 1'b0; m1_read = 1'b0;
    idle(4);
    cnt_en = 0;
    chk("rr_m0_count", c0, 2);
    chk("rr_m1_count", c1, 2);
    chk("fp_m0_count", f0, 4);
    chk("fp_m1_count", f1, 0);

    // abort: m1 drops its read in the grant's issue cycle, after m0 set last-grant to 0
    master_req(0, SYSID_ADDR_TS);
    idle(3);
    clr_cnt();
    cnt_en = 1;
    @(posedge clock); #1 set_req(1, 1'b1, 1'b1);
    @(posedge clock); #1 set_req(1, 1'b0, 1'b1);
    idle(4);
    cnt_en = 0;
    chk("abort_m1_valid_count", c1, 0);
    fork
      master_req(0, SYSID_ADDR_TS);
      master_req(1, SYSID_ADDR_TS);
    join
    idle(3);

    // reset asserted during the response cycle
    master_req(0, SYSID_ADDR_TS);
    #1 reset = 1'b1;
    #1;
    chk("rst_resp_m0_valid", {31'b0, m0_readdatavalid}, 32'h0);
    chk("rst_resp_m0_data", m0_readdata, 32'h0);
    chk("rst_resp_s_address", {31'b0, s_address}, 32'h0);
    idle(2);
    reset = 1'b0;
    master_req(1, SYSID_ADDR_TS);
    idle(3);

    // randomized traffic with occasional resets
    fork
      rand_master(0, 60);
      rand_master(1, 60);
      begin
        repeat (3) begin
          repeat ($urandom_range(100, 250)) @(posedge clock);
          #1 reset = 1'b1;
          @(posedge clock); #1 reset = 1'b0;
        end
      end
    join
    idle(6);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sm_mcu_sysid_arbiter.md
SM_MCU_SYSID_ARBITER -- requirements
Module: sm_mcu_sysid_arbiter

Interface
REQ-001 Parameter: DATA_W, default 32, width of readdata paths.
REQ-002 Parameter: FIXED_PRIORITY, default 0; 0 = round-robin, 1 = master 0 always wins ties.
REQ-003 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-004 clock  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 m0_read  input  1  master 0 read request, held until accepted.
REQ-007 m0_address  input  1  master 0 word address (0 = system ID, 1 = timestamp).
REQ-008 m0_waitrequest  output  1  master 0 read not yet accepted.
REQ-009 m0_readdata  output  DATA_W  master 0 returned data.
REQ-010 m0_readdatavalid  output  1  one-cycle pulse qualifying m0_readdata.
REQ-011 m1_read, m1_address, m1_waitrequest, m1_readdata, m1_readdatavalid: identical to REQ-006..REQ-010 for master 1.
REQ-012 s_address  output  1  address driven to the shared sysid slave.
REQ-013 s_readdata  input  DATA_W  combinational data returned by the sysid slave.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE and RESP; reset state IDLE.
REQ-015 IDLE: no read pending -> stay IDLE; any mN_read high -> latch grant index, go ISSUE.
REQ-016 Both reads high in IDLE: round-robin grants the master not granted last; FIXED_PRIORITY=1 grants master 0.
REQ-017 Last-grant register SHALL reset to 1, so master 0 wins the first tie.
REQ-018 ISSUE: s_address = granted master's address; if granted mN_read still high, capture s_readdata into data register, update last-grant, go RESP; else go IDLE with no response and last-grant unchanged.
REQ-019 mN_waitrequest SHALL be combinational: mN_read AND NOT (state = ISSUE AND grant = N).
REQ-020 RESP: granted mN_readdatavalid = 1 for exactly one cycle with mN_readdata = captured word; then IDLE.
REQ-021 Latency SHALL be fixed: read seen in IDLE at cycle T, accepted in T+1, readdatavalid in T+2; peak throughput one read per 3 cycles.
REQ-022 Non-granted master SHALL see waitrequest high throughout and readdatavalid low.
REQ-023 s_address SHALL be 0 outside ISSUE.
REQ-024 mN_readdata SHALL hold its last captured value between responses; only readdatavalid qualifies it.
REQ-025 A master whose read is served in RESP and re-asserted in the next IDLE competes normally; round-robin then grants the other master if both pending.

Reset
REQ-026 Reset SHALL force state IDLE, grant 0, last-grant 1, data registers 0, all readdatavalid 0, s_address 0, asynchronously.
REQ-027 Reset asserted in ISSUE or RESP SHALL abort the transaction; no readdatavalid SHALL pulse after reset release until a new request completes.

Structure
REQ-028 Shared package sm_mcu_sysid_pkg SHALL hold the FSM state type and constants SYSID_ADDR_ID = 0, SYSID_ADDR_TS = 1.
REQ-029 Two-requester grant logic SHALL be one sub-module, sm_mcu_rr_arb2 (inputs req[1:0], last_grant, fixed_priority; output grant).
REQ-030 All other logic SHALL reside in the top module; no additional sub-modules.

Verification
REQ-031 Slave model: s_readdata = s_address ? 32'h5409_7537 : 32'h0000_0000.
REQ-032 Single read: m0_read=1, m0_address=1 at T -> m0_waitrequest low at T+1, m0_readdatavalid=1 with 32'h5409_7537 at T+2, m1 outputs idle.
REQ-033 Tie after reset: m0 and m1 read together (addresses 0 and 1) -> m0 served first (data 0), m1 served next (data 32'h5409_7537), m1 waitrequest high until its ISSUE.
REQ-034 Fairness: both masters continuously requesting for 12 cycles -> grants alternate m0, m1, m0, m1; FIXED_PRIORITY=1 -> m0 served all 4.
REQ-035 Abort: m1_read dropped in the cycle after grant -> FSM returns IDLE, no m1_readdatavalid, last-grant unchanged.
REQ-036 Reset in RESP: reset pulses during RESP -> readdatavalid low immediately, all outputs at reset values, next request completes with normal T+2 latency.
